pwm_output_bank: RTL and testbench

Multi-channel, parametrised PWM output stage for the rocker drive path. Each channel converts a small setpoint level (motor frequency, amplitude, or any later actuator) into a duty value. It drives a PWM pin from one shared free-running period counter. Duty changes are applied only at period boundaries, with optional slew limiting, so setpoint jumps never produce runt pulses or abrupt motor steps.

---
 rtl/pwm_output_bank.sv | 104 ++++++++++
 tb/tb_pwm_output_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_bank.sv
// Multi-channel PWM output stage driven by one shared free-running period counter.
// Define PWM_OUTPUT_RAMP_EN to slew-limit active duty by RAMP_STEP per period.
module pwm_output_bank #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned LEVEL_W   = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STEP      = 8192,
  parameter int unsigned RAMP_STEP = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*LEVEL_W-1:0]  level,
  input  logic                         level_valid,
  input  logic [CHANNELS-1:0]          enable,
  output logic [CHANNELS-1:0]          pwm,
  output logic                         period_start,
  output logic [CHANNELS-1:0]          settled
);

  localparam int unsigned      ProdW    = LEVEL_W + 32;
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [ProdW-1:0] SatLimit = ProdW'(CntMax);

`ifdef PWM_OUTPUT_RAMP_EN
  localparam bit RampEn = 1'b1;
`else
  localparam bit RampEn = 1'b0;
`endif

  // Without ramping the limit spans the whole duty range, so every boundary jumps to target.
  localparam logic [CNT_W:0] StepLim = RampEn ? (CNT_W+1)'(RAMP_STEP) : {1'b0, CntMax};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             boundary;

  assign cnt_d          = cnt_q + CNT_W'(1);
  assign boundary       = (cnt_q == CntMax);
  assign period_start_d = (cnt_q == '0);
  assign period_start   = period_start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [LEVEL_W-1:0] lvl;
    logic [ProdW-1:0]   prod;
    logic [CNT_W-1:0]   lvl_duty;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   diff, stepped;
    logic               up;
    logic               pwm_q, pwm_d;

    assign lvl      = level[i*LEVEL_W +: LEVEL_W];
    assign prod     = ProdW'(lvl) * ProdW'(STEP);
    assign lvl_duty = (prod > SatLimit) ? CntMax : prod[CNT_W-1:0];
    assign target_d = level_valid ? lvl_duty : target_q;

    assign up   = (target_q > active_q);
    assign diff = up ? (target_q - active_q) : (active_q - target_q);

    // Step toward target; landing exactly on it whenever the gap fits in one step.
    always_comb begin
      stepped = target_q;
      if ({1'b0, diff} > StepLim) begin
        stepped = up ? (active_q + StepLim[CNT_W-1:0]) : (active_q - StepLim[CNT_W-1:0]);
      end
    end

    always_comb begin
      active_d = active_q;
      if (boundary) begin
        active_d = enable[i] ? stepped : '0;
      end
    end

    // At the boundary cnt is at its maximum, so the compare is always false there.
    assign pwm_d = enable[i] & (cnt_q < active_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        target_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        target_q <= target_d;
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm[i]     = pwm_q;
    assign settled[i] = (active_q == target_q);
  end

endmodule

// File: tb/tb_pwm_output_bank.sv
// Self-checking bench for pwm_output_bank: directed duty sequences, a vector table and
// randomized traffic against an integer reference model of the period/duty rules.
module tb_pwm_output_bank;

  localparam int LW     = 3;
  localparam int CW     = 8;
  localparam int ST     = 32;
  localparam int RS     = 16;
  localparam int PERIOD = 256;
  localparam int CMAX   = PERIOD - 1;

`ifdef PWM_OUTPUT_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] level = '0;
  logic       level_valid = 1'b0;
  logic [1:0] enable = '0;
  logic [1:0] pwm;
  logic       period_start;
  logic [1:0] settled;

  pwm_output_bank #(
    .CHANNELS (2),
    .LEVEL_W  (LW),
    .CNT_W    (CW),
    .STEP     (ST),
    .RAMP_STEP(RS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .level_valid (level_valid),
    .enable      (enable),
    .pwm         (pwm),
    .period_start(period_start),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: position in period, target and applied duty per channel.
  int         m_cnt;
  int         m_tgt[2];
  int         m_act[2];
  logic [1:0] e_pwm;
  logic       e_ps;

  function automatic int ref_step(int a, int t);
    if (RAMP) begin
      if (t > a + RS) return a + RS;
      if (t < a - RS) return a - RS;
    end
    return t;
  endfunction

  function automatic int ref_target(int l);
    int d = l * ST;
    return (d > CMAX) ? CMAX : d;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_tgt = '{0, 0};
    m_act = '{0, 0};
    e_pwm = 2'b00;
    e_ps  = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) e_pwm[i] = enable[i] && (m_cnt < m_act[i]);
      e_ps = (m_cnt == 0);
      if (m_cnt == CMAX) begin
        for (int i = 0; i < 2; i++) m_act[i] = enable[i] ? ref_step(m_act[i], m_tgt[i]) : 0;
      end
      if (level_valid) begin
        for (int i = 0; i < 2; i++) m_tgt[i] = ref_target(int'(level[i*LW +: LW]));
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  endtask

  task automatic check_out(string name);
    logic [4:0] got, exp;
    logic [1:0] s;
    for (int i = 0; i < 2; i++) s[i] = (m_act[i] == m_tgt[i]);
    got = {pwm, period_start, settled};
    exp = {e_pwm, e_ps, s};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t pwm/ps/settled got %b required %b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out("cycle");
  endtask

  task automatic timeout(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s t=%0t got timeout required event", name, $time);
  endtask

  // Counts high cycles of each channel over one full period starting at period_start.
  task automatic measure_period(output int h0, output int h1, output int s0);
    int g = 0;
    h0 = -1;
    h1 = -1;
    s0 = -1;
    while (period_start !== 1'b1 && g < 300) begin
      cycle();
      g++;
    end
    if (period_start !== 1'b1) begin
      timeout("period_start_wait");
      return;
    end
    h0 = int'(pwm[0]);
    h1 = int'(pwm[1]);
    s0 = int'(settled[0]);
    repeat (PERIOD - 1) begin
      cycle();
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  task automatic wait_model_cnt(int c);
    int g = 0;
    while (m_cnt != c && g < 400) begin
      cycle();
      g++;
    end
    if (m_cnt != c) timeout("cnt_wait");
  endtask

  typedef struct {
    logic [2:0] l0;
    logic [2:0] l1;
    logic [1:0] en;
    int         d0;
    int         d1;
    logic [1:0] s;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got no finish required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, h1, s0, n, exp0;

    tbl[0] = '{3'd4, 3'd0, 2'b11, 128, 0,   2'b11};
    tbl[1] = '{3'd7, 3'd0, 2'b11, 224, 0,   2'b11};
    tbl[2] = '{3'd0, 3'd7, 2'b11, 0,   224, 2'b11};
    tbl[3] = '{3'd7, 3'd7, 2'b01, 224, 0,   2'b01};
    tbl[4] = '{3'd3, 3'd5, 2'b10, 0,   160, 2'b10};
    tbl[5] = '{3'd2, 3'd2, 2'b11, 64,  64,  2'b11};

    // Reset state
    model_reset();
    #1;
    check_out("reset_state");
    check_int("reset_settled", int'(settled), 3);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
    check_int("release_period_start", int'(period_start), 1);
    cycle();

    // Single strobe of level 4 on ch0 from zero duty
    level       = {3'd0, 3'd4};
    enable      = 2'b11;
    level_valid = 1'b1;
    cycle();
    level_valid = 1'b0;
    check_int("settled0_before_boundary", int'(settled[0]), 0);
    for (int k = 0; k < 9; k++) begin
      measure_period(h0, h1, s0);
      exp0 = RAMP ? ((RS * (k + 1) > 128) ? 128 : RS * (k + 1)) : 128;
      check_int($sformatf("duty0_p%0d", k), h0, exp0);
      check_int($sformatf("duty1_p%0d", k), h1, 0);
      check_int($sformatf("settled0_p%0d", k), s0, (RAMP && k < 7) ? 0 : 1);
    end

    // Reset while ch0 is high, then period_start spacing after release
    repeat (20) cycle();
    check_int("pwm0_high_pre_reset", int'(pwm[0]), 1);
    rst = 1'b1;
    #1;
    model_reset();
    check_int("reset_mid_pwm", int'(pwm), 0);
    check_int("reset_mid_ps", int'(period_start), 0);
    check_int("reset_mid_settled", int'(settled), 3);
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check_int("ps_first_after_release", int'(period_start), 1);
    n = 0;
    do begin
      cycle();
      n++;
    end while (period_start !== 1'b1 && n < 400);
    check_int("ps_interval", n, PERIOD);

    // Vector table: settled duty per level/enable pattern
    foreach (tbl[v]) begin
      level       = {tbl[v].l1, tbl[v].l0};
      enable      = tbl[v].en;
      level_valid = 1'b1;
      cycle();
      level_valid = 1'b0;
      repeat (16 * PERIOD) cycle();
      measure_period(h0, h1, s0);
      check_int($sformatf("tbl%0d_duty0", v), h0, tbl[v].d0);
      check_int($sformatf("tbl%0d_duty1", v), h1, tbl[v].d1);
      check_int($sformatf("tbl%0d_settled", v), int'(settled), int'(tbl[v].s));
    end

    // Strobe on the boundary cycle is deferred one period; one cycle earlier is not
    wait_model_cnt(CMAX);
    level       = {3'd2, 3'd7};
    level_valid = 1'b1;
    cycle();
    level_valid = 1'b0;
    measure_period(h0, h1, s0);
    check_int("bnd_strobe_p0_duty0", h0, 64);
    check_int("bnd_strobe_p0_duty1", h1, 64);
    measure_period(h0, h1, s0);
    check_int("bnd_strobe_p1_duty0", h0, RAMP ? 80 : 224);
    check_int("bnd_strobe_p1_duty1", h1, 64);
    wait_model_cnt(CMAX - 1);
    level       = {3'd2, 3'd0};
    level_valid = 1'b1;
    cycle();
    level_valid = 1'b0;
    measure_period(h0, h1, s0);
    check_int("pre_bnd_strobe_duty0", h0, RAMP ? 80 : 0);

    // Disable/re-enable ch0 with ch1 running
    rst = 1'b1;
    #1;
    model_reset();
    check_out("reset_before_enable_test");
    cycle();
    rst         = 1'b0;
    level       = {3'd3, 3'd4};
    enable      = 2'b11;
    level_valid = 1'b1;
    cycle();
    level_valid = 1'b0;
    repeat (10 * PERIOD) cycle();
    measure_period(h0, h1, s0);
    check_int("en_settled_duty0", h0, 128);
    check_int("en_settled_duty1", h1, 96);
    wait_model_cnt(60);
    check_int("pwm0_mid_high", int'(pwm[0]), 1);
    enable = 2'b10;
    cycle();
    check_int("pwm0_low_next_edge", int'(pwm[0]), 0);
    check_int("pwm1_unaffected", int'(pwm[1]), 1);
    for (int k = 0; k < 2; k++) begin
      measure_period(h0, h1, s0);
      check_int($sformatf("dis_p%0d_duty0", k), h0, 0);
      check_int($sformatf("dis_p%0d_duty1", k), h1, 96);
    end
    enable = 2'b11;
    for (int k = 0; k < 4; k++) begin
      measure_period(h0, h1, s0);
      exp0 = (k == 0) ? 0 : (RAMP ? RS * k : 128);
      check_int($sformatf("reen_p%0d_duty0", k), h0, exp0);
      check_int($sformatf("reen_p%0d_duty1", k), h1, 96);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 12000; c++) begin
      level_valid = 1'b0;
      if ($urandom % 150 == 0) begin
        level       = 6'($urandom);
        level_valid = 1'b1;
      end
      if ($urandom % 400 == 0) enable = 2'($urandom);
      if ($urandom % 2500 == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_out("rand_reset");
        repeat ($urandom_range(0, 2)) cycle();
        rst = 1'b0;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
